// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, baud divisor and frame timing used to size
// the receive FIFO and its character-timeout default.
package uart_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned UART_DIVISOR  = 286;
    localparam int unsigned FRAME_BITS    = 10;
    localparam int unsigned CHAR_CLKS     = FRAME_BITS * UART_DIVISOR;

    // Character timeout is four idle frame times.
    localparam int unsigned TIMEOUT_CHARS = 4;

    localparam int unsigned DEFAULT_DEPTH_LOG2 = 4;
    localparam int unsigned DEFAULT_TRIGGER    = 8;
    localparam int unsigned DEFAULT_TIMEOUT    = TIMEOUT_CHARS * CHAR_CLKS;

    typedef logic [BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: synchronous write port and an
// asynchronous read port so the head byte can fall through combinationally.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_DEPTH_LOG2,
    parameter int unsigned DATA_W = BYTE_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Contents are deliberately left out of reset.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: edge-detected byte capture into a FWFT FIFO with sticky
// overrun, fill-level interrupt and character-timeout interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int unsigned TRIGGER    = DEFAULT_TRIGGER,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    input  logic                  rd_en,
    output logic [BYTE_W-1:0]     rd_data,
    output logic                  data_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  irq,
    output logic                  irq_timeout
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TRIG_LVL = CNT_W'(TRIGGER);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    logic              rx_valid_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              irq_timeout_q, irq_timeout_d;

    logic              push_req;
    logic              full;
    logic              empty;
    logic              push_eff;
    logic              pop_eff;
    logic [BYTE_W-1:0] mem_rd_data;

    assign push_req = rx_valid & ~rx_valid_q;
    assign full     = (count_q == FULL_LVL);
    assign empty    = (count_q == '0);

    // When full, a same-cycle pop frees the slot the incoming byte needs.
    assign push_eff = push_req & (~full | rd_en);
    assign pop_eff  = rd_en & ~empty;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overrun_d     = overrun_q;
        tmo_cnt_d     = tmo_cnt_q;
        irq_timeout_d = 1'b0;

        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new drop event takes priority over a clear in the same cycle.
        if (push_req && full && !rd_en) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (push_eff || pop_eff || empty) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end

        irq_timeout_d = (tmo_cnt_d == TMO_MAX) && (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            tmo_cnt_q     <= '0;
            irq_timeout_q <= 1'b0;
        end else begin
            rx_valid_q    <= rx_valid;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            tmo_cnt_q     <= tmo_cnt_d;
            irq_timeout_q <= irq_timeout_d;
        end
    end

    uart_fifo_mem #(
        .ADDR_W (PTR_W),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_eff),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    assign data_ready  = ~empty;
    assign rd_data     = empty ? '0 : mem_rd_data;
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign irq_timeout = irq_timeout_q;
    assign irq         = (count_q >= TRIG_LVL) | irq_timeout_q;

    // Occupancy never exceeds depth and always matches the pointer distance.
    a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= FULL_LVL);
    a_ptr_match : assert property (@(posedge clk) disable iff (rst)
        (wr_ptr_q - rd_ptr_q) == count_q[PTR_W-1:0]);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected bytes, a negedge
// monitor checks every host pop against the queue; flags are checked inline.
module tb_uart_rx_fifo;

    localparam int unsigned TIMEOUT = 11440;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] rd_data;
    logic       data_ready;
    logic [4:0] count;
    logic       overrun;
    logic       irq;
    logic       irq_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .TRIGGER    (8),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .data_ready  (data_ready),
        .count       (count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .irq         (irq),
        .irq_timeout (irq_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rising edge of rx_valid, held for 'hold' cycles, then low for one.
    task automatic push_byte(input logic [7:0] b, input bit accept, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        if (accept) sb.push_back(b);
        repeat (hold) tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    // Scoreboard monitor: every cycle the host pops, compare against the model.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst && rd_en) begin
            if (sb.size() > 0) begin
                exp_b = sb.pop_front();
                check("pop_ready", 32'(data_ready), 32'd1);
                check("pop_data", 32'(rd_data), 32'(exp_b));
            end else begin
                check("pop_empty_ready", 32'(data_ready), 32'd0);
            end
        end
    end

    initial begin
        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (100) tick();
        check("idle_ready", 32'(data_ready), 32'd0);
        check("idle_count", 32'(count), 32'd0);
        check("idle_rd_data", 32'(rd_data), 32'h00);
        check("idle_irq", 32'(irq), 32'd0);
        check("idle_overrun", 32'(overrun), 32'd0);
        check("idle_irq_timeout", 32'(irq_timeout), 32'd0);

        // Single byte, rx_valid held 3 cycles
        rx_data  = 8'h7A;
        rx_valid = 1'b1;
        sb.push_back(8'h7A);
        tick();
        check("single_ready_lat", 32'(data_ready), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'h7A);
        tick();
        tick();
        check("single_one_push", 32'(count), 32'd1);
        rx_valid = 1'b0;
        tick();
        pop_n(1);
        check("single_pop_count", 32'(count), 32'd0);
        check("single_pop_ready", 32'(data_ready), 32'd0);

        // Pop while empty is ignored
        pop_n(1);
        check("empty_pop_count", 32'(count), 32'd0);

        // Fill past full: 17 edges, the last dropped
        for (int i = 0; i < 17; i++) push_byte(8'(i), i < 16, 1);
        check("full_count", 32'(count), 32'd16);
        check("full_overrun", 32'(overrun), 32'd1);
        check("full_irq", 32'(irq), 32'd1);
        check("full_head", 32'(rd_data), 32'h00);
        pop_n(16);
        check("drain_count", 32'(count), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun_clr", 32'(overrun), 32'd0);

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1, 1);
        check("full2_count", 32'(count), 32'd16);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        rd_en    = 1'b1;
        sb.push_back(8'h55);
        tick();
        rd_en    = 1'b0;
        rx_valid = 1'b0;
        tick();
        check("pp_count", 32'(count), 32'd16);
        check("pp_overrun", 32'(overrun), 32'd0);
        check("pp_head", 32'(rd_data), 32'h21);
        pop_n(16);
        check("pp_drain_count", 32'(count), 32'd0);

        // Threshold and timeout
        for (int i = 0; i < 7; i++) push_byte(8'h30 + 8'(i), 1'b1, 1);
        check("thr7_count", 32'(count), 32'd7);
        check("thr7_irq", 32'(irq), 32'd0);
        push_byte(8'h37, 1'b1, 1);
        check("thr8_irq", 32'(irq), 32'd1);
        check("thr8_irq_timeout", 32'(irq_timeout), 32'd0);
        pop_n(5);
        check("tmo_count", 32'(count), 32'd3);
        check("tmo_irq_low", 32'(irq), 32'd0);
        repeat (TIMEOUT - 1) tick();
        check("tmo_early", 32'(irq_timeout), 32'd0);
        tick();
        check("tmo_fire", 32'(irq_timeout), 32'd1);
        check("tmo_irq", 32'(irq), 32'd1);
        pop_n(1);
        check("tmo_clear", 32'(irq_timeout), 32'd0);
        check("tmo_clear_count", 32'(count), 32'd2);
        check("tmo_clear_irq", 32'(irq), 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) push_byte(8'h38 + 8'(i), 1'b1, 1);
        check("mid_count", 32'(count), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_irq_timeout", 32'(irq_timeout), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        push_byte(8'hA5, 1'b1, 1);
        check("post_rst_data", 32'(rd_data), 32'hA5);
        check("post_rst_count", 32'(count), 32'd1);
        pop_n(1);
        check("post_rst_drain", 32'(count), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
